// File: rtl/imem_loader.sv
// Byte-serial program loader: parses a length/payload/checksum frame and writes
// big-endian 32-bit words into instruction memory while holding the CPU in reset.
module imem_loader #(
   parameter int          DEPTH_WORDS    = 256,
   parameter logic [31:0] BASE_ADDR      = 32'h0,
   parameter int          TIMEOUT_CYCLES = 65535
) (
   input  logic        SYS_clk,
   input  logic        SYS_reset,
   input  logic        LD_start,
   input  logic        LD_byte_valid,
   input  logic [7:0]  LD_byte,
   output logic        LD_byte_ready,
   output logic        IMEM_wr_en,
   output logic [31:0] IMEM_wr_addr,
   output logic [31:0] IMEM_wr_data,
   output logic        LD_cpu_hold,
   output logic        LD_busy,
   output logic        LD_done,
   output logic        LD_error,
   output logic [1:0]  LD_err_code
);

   localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
   } state_t;

   state_t        state;
   logic [7:0]    len_hi;
   logic [15:0]   n_words;
   logic [15:0]   word_cnt;
   logic [1:0]    byte_idx;
   logic [31:0]   word_sr;
   logic [31:0]   addr;
   logic [7:0]    csum;
   logic [TW-1:0] idle_cnt;

   logic        accept;
   logic [15:0] n_in;
   logic        len_bad;
   logic        timeout_hit;

   assign accept      = LD_byte_valid & LD_byte_ready;
   assign n_in        = {len_hi, LD_byte};
   assign len_bad     = (n_in == 16'd0) || ({16'd0, n_in} > DEPTH_U);
   assign timeout_hit = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge SYS_clk or posedge SYS_reset) begin
      if (SYS_reset) begin
         state         <= S_IDLE;
         len_hi        <= '0;
         n_words       <= '0;
         word_cnt      <= '0;
         byte_idx      <= '0;
         word_sr       <= '0;
         addr          <= '0;
         csum          <= '0;
         idle_cnt      <= '0;
         LD_byte_ready <= 1'b0;
         IMEM_wr_en    <= 1'b0;
         IMEM_wr_addr  <= '0;
         IMEM_wr_data  <= '0;
         LD_cpu_hold   <= 1'b0;
         LD_busy       <= 1'b0;
         LD_done       <= 1'b0;
         LD_error      <= 1'b0;
         LD_err_code   <= 2'd0;
      end else begin
         IMEM_wr_en <= 1'b0;
         case (state)
            // DONE and ERROR are sticky; a new start behaves exactly like IDLE.
            S_IDLE, S_DONE, S_ERROR: begin
               if (LD_start) begin
                  state         <= S_LEN_HI;
                  LD_busy       <= 1'b1;
                  LD_cpu_hold   <= 1'b1;
                  LD_done       <= 1'b0;
                  LD_error      <= 1'b0;
                  LD_err_code   <= 2'd0;
                  addr          <= BASE_ADDR;
                  csum          <= '0;
                  word_cnt      <= '0;
                  byte_idx      <= '0;
                  idle_cnt      <= '0;
                  LD_byte_ready <= 1'b1;
               end
            end
            S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM: begin
               if (accept) begin
                  idle_cnt <= '0;
                  case (state)
                     S_LEN_HI: begin
                        len_hi <= LD_byte;
                        state  <= S_LEN_LO;
                     end
                     S_LEN_LO: begin
                        if (len_bad) begin
                           state         <= S_ERROR;
                           LD_error      <= 1'b1;
                           LD_busy       <= 1'b0;
                           LD_byte_ready <= 1'b0;
                           LD_err_code   <= 2'd1;
                        end else begin
                           n_words <= n_in;
                           state   <= S_DATA;
                        end
                     end
                     S_DATA: begin
                        csum     <= csum + LD_byte;
                        byte_idx <= byte_idx + 2'd1;
                        word_sr  <= {word_sr[23:0], LD_byte};
                        // Strobe is registered here so it is high during the WRITE cycle.
                        if (byte_idx == 2'd3) begin
                           state         <= S_WRITE;
                           LD_byte_ready <= 1'b0;
                           IMEM_wr_en    <= 1'b1;
                           IMEM_wr_addr  <= addr;
                           IMEM_wr_data  <= {word_sr[23:0], LD_byte};
                        end
                     end
                     S_CSUM: begin
                        LD_byte_ready <= 1'b0;
                        LD_busy       <= 1'b0;
                        if (LD_byte == csum) begin
                           state       <= S_DONE;
                           LD_done     <= 1'b1;
                           LD_cpu_hold <= 1'b0;
                        end else begin
                           state       <= S_ERROR;
                           LD_error    <= 1'b1;
                           LD_err_code <= 2'd2;
                        end
                     end
                     default: ;
                  endcase
               end else if (timeout_hit) begin
                  state         <= S_ERROR;
                  LD_error      <= 1'b1;
                  LD_busy       <= 1'b0;
                  LD_byte_ready <= 1'b0;
                  LD_err_code   <= 2'd3;
               end else begin
                  idle_cnt <= idle_cnt + 1'b1;
               end
            end
            S_WRITE: begin
               addr          <= addr + 32'd4;
               word_cnt      <= word_cnt + 16'd1;
               idle_cnt      <= '0;
               LD_byte_ready <= 1'b1;
               state         <= (word_cnt + 16'd1 == n_words) ? S_CSUM : S_DATA;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-serial program loader: the writer side of the CPU's instruction memory.
- Receives a framed program image over a valid/ready byte stream and assembles big-endian 32-bit words.
- Writes each word through the IMEM write port and holds the CPU in reset (LD_cpu_hold) for the whole session.
- Sits beside the system top; LD_cpu_hold is ORed into the CPU reset by the integrator.

Parameters:
- DEPTH_WORDS, 256, IMEM capacity in words; a frame with more words is rejected.
- BASE_ADDR, 32'h0, byte address of the first written word; must be word aligned.
- TIMEOUT_CYCLES, 65535, maximum idle cycles allowed between accepted bytes inside a frame.

Ports:
- SYS_clk  input  1  clock; all state updates on the rising edge.
- SYS_reset  input  1  asynchronous, active-high reset.
- LD_start  input  1  single-cycle pulse that opens a load session.
- LD_byte_valid  input  1  LD_byte holds a valid byte.
- LD_byte  input  8  stream byte.
- LD_byte_ready  output  1  loader can accept a byte this cycle.
- IMEM_wr_en  output  1  one-cycle write strobe.
- IMEM_wr_addr  output  32  byte address of the word being written (word aligned).
- IMEM_wr_data  output  32  word being written.
- LD_cpu_hold  output  1  keep the CPU in reset.
- LD_busy  output  1  session in progress.
- LD_done  output  1  last session completed cleanly.
- LD_error  output  1  last session failed.
- LD_err_code  output  2  0 none, 1 bad length, 2 checksum mismatch, 3 timeout.

Behaviour:
- Frame format: LEN_HI, LEN_LO (N = {LEN_HI, LEN_LO} words), then 4*N payload bytes, then 1 checksum byte.
  - Payload bytes arrive MSB first: the first byte goes to bits 31:24.
  - Checksum is the 8-bit sum, mod 256, of the payload bytes only.
- Byte handshake: a byte is accepted on a rising edge where LD_byte_valid and LD_byte_ready are both 1.
  - LD_byte_ready is registered. It is 1 only in LEN_HI, LEN_LO, DATA and CSUM.
  - The source must hold LD_byte stable while LD_byte_valid=1 and LD_byte_ready=0.
- Reset (asynchronous): state goes to IDLE. Every output is 0, including LD_cpu_hold. Internal word counter, byte index, address and checksum are cleared.
- IDLE: on LD_start, go to LEN_HI. Set LD_busy=1 and LD_cpu_hold=1, clear LD_done, LD_error and LD_err_code. Load the address register with BASE_ADDR and clear the checksum.
- LEN_HI → LEN_LO on an accepted byte.
- LEN_LO, on an accepted byte:
  - If N==0 or N>DEPTH_WORDS: go to ERROR with code 1. No write is issued.
  - Otherwise go to DATA.
- DATA: accept 4 bytes, shifting each into a 32-bit word and adding each to the checksum. After the 4th byte, go to WRITE.
- WRITE (exactly one cycle):
  - IMEM_wr_en=1, IMEM_wr_addr = current address, IMEM_wr_data = assembled word. LD_byte_ready=0.
  - Address then increments by 4 and the word counter by 1.
  - Next state is DATA if words remain, otherwise CSUM.
  - Latency: wr_en asserts on the cycle after the 4th byte is accepted.
- CSUM, on an accepted byte:
  - Byte equals the running sum: go to DONE.
  - Otherwise: go to ERROR with code 2.
  - Words already written are not rolled back.
- DONE: LD_done=1, LD_busy=0, LD_cpu_hold=0.
- ERROR: LD_error=1, LD_busy=0, LD_cpu_hold stays 1, so the CPU never runs a bad image.
- Leaving DONE or ERROR: both persist until the next LD_start, which restarts as if from IDLE.
- Timeout:
  - In LEN_HI, LEN_LO, DATA and CSUM an idle counter increments every cycle without an accepted byte. It resets on each accepted byte and on state entry.
  - Reaching TIMEOUT_CYCLES goes to ERROR with code 3.
  - The counter does not run in IDLE, WRITE, DONE or ERROR.
- LD_start while LD_busy=1 is ignored.
- IMEM_wr_addr and IMEM_wr_data hold their last values when IMEM_wr_en=0; IMEM_wr_en must be sampled.
- Address arithmetic is 32-bit and never wraps, because N is bounded by DEPTH_WORDS.

Test Plan:
- Clean load: LD_start, then bytes 00 02 20 08 00 05 20 09 00 0A 60 → two writes, (addr 0x0, 0x20080005) then (0x4, 0x2009000A). Then LD_done=1, LD_err_code=0, LD_cpu_hold falls 1→0.
- Bad checksum: same frame but last byte 61 → both writes still occur, then LD_error=1, LD_err_code=2, LD_cpu_hold stays 1.
- Bad length: frame 00 00 → error code 1 with no IMEM_wr_en. Frame 01 01 (N=257, DEPTH_WORDS=256) → error code 1, no writes.
- Timeout: TIMEOUT_CYCLES=16, send 00 01 20 then idle → LD_err_code=3 exactly 16 cycles after the byte 20 is accepted, with no write.
- Back-pressure and ignore: hold LD_byte_valid=1 continuously → no byte consumed during the WRITE cycle (LD_byte_ready=0). An LD_start pulse mid-frame changes nothing.
- Reset mid-DATA: assert SYS_reset after 2 payload bytes → all outputs 0 immediately. A new LD_start with a clean 1-word frame writes at BASE_ADDR and completes with LD_done=1.
